// File: rtl/lcd_frame_sequencer_pkg.sv
// lcd_seq_pkg: shared types and sizing helpers for the LCD frame sequencer.
// Holds the FSM state enum, frame/pixel size helpers and counter width helper.
package lcd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Clocks per frame handed to the timing generator.
    function automatic int frame_cyc(input int h_total, input int v_total);
        return h_total * v_total;
    endfunction

    // Active pixels a well-formed frame must deliver.
    function automatic int pix_exp(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_pix_addr_gen.sv
// lcd_pix_addr_gen: framebuffer read address and per-frame pixel count check.
// Ports: clr/en/frame_end/err_clr from the FSM, pix_active in; pix_valid, pix_addr, px_err out.
module lcd_pix_addr_gen
    import lcd_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int PCNT_W  = 8,
    parameter int PIX_EXP = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              pix_active,
    input  logic              frame_end,
    input  logic              err_clr,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              px_err
);

    localparam logic [PCNT_W-1:0] PCNT_EXP = PCNT_W'(PIX_EXP);

    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              px_err_q, px_err_d;

    logic              hit;
    logic [ADDR_W-1:0] addr_base;
    logic [PCNT_W-1:0] pcnt_base;

    always_comb begin
        hit = en & pix_active;
        // A pixel in the frame_start cycle itself must already see a cleared count.
        addr_base = clr ? '0 : addr_cnt_q;
        pcnt_base = clr ? '0 : pcnt_q;
        addr_cnt_d = hit ? addr_base + 1'b1 : addr_base;
        pcnt_d = hit ? pcnt_base + 1'b1 : pcnt_base;
        pix_valid_d = hit;
        pix_addr_d = hit ? addr_base : pix_addr_q;
        px_err_d = px_err_q;
        if (err_clr) begin
            px_err_d = 1'b0;
        end
        // pcnt_d already includes a pixel on the final RUN cycle.
        if (frame_end && (pcnt_d != PCNT_EXP)) begin
            px_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt_q  <= '0;
            pcnt_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_addr_q  <= '0;
            px_err_q    <= 1'b0;
        end else begin
            addr_cnt_q  <= addr_cnt_d;
            pcnt_q      <= pcnt_d;
            pix_valid_q <= pix_valid_d;
            pix_addr_q  <= pix_addr_d;
            px_err_q    <= px_err_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_addr  = pix_addr_q;
    assign px_err    = px_err_q;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: gates the LCD timing generator one frame at a time with blanking gaps.
// Ports: start/stop/num_frames control, pix_active in; gen_en, busy, frame pulses, counters, pixel strobe/address, px_err out.
module lcd_frame_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int H_TOTAL  = 8,
    parameter int V_TOTAL  = 16,
    parameter int H_ACTIVE = 5,
    parameter int V_ACTIVE = 10,
    parameter int GAP_CYC  = 4,
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic              pix_active,
    output logic              gen_en,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_cnt,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              px_err
);

    localparam int FRAME_CYC = frame_cyc(H_TOTAL, V_TOTAL);
    localparam int PIX_EXP   = pix_exp(H_ACTIVE, V_ACTIVE);
    localparam int CYC_W     = cnt_width(FRAME_CYC);
    localparam int GAP_W     = cnt_width(GAP_CYC);
    localparam int PCNT_W    = cnt_width(FRAME_CYC + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(FRAME_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  frames_cnt_q, frames_cnt_d;
    logic [CNT_W-1:0]  num_frames_q, num_frames_d;
    logic              stop_pend_q, stop_pend_d;
    logic              frame_done_q, frame_done_d;

    logic [CNT_W-1:0]  nf;
    logic              frame_end;
    logic              err_clr;
    logic              run;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        gap_d        = gap_q;
        frames_cnt_d = frames_cnt_q;
        num_frames_d = num_frames_q;
        stop_pend_d  = stop_pend_q;
        frame_done_d = 1'b0;
        frame_end    = 1'b0;
        err_clr      = 1'b0;
        // Saturating increment keeps continuous mode from wrapping.
        nf = (frames_cnt_q == CNT_MAX) ? CNT_MAX : frames_cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                // A coincident stop is simply not looked at here.
                if (start) begin
                    state_d      = S_RUN;
                    cyc_d        = '0;
                    num_frames_d = num_frames;
                    frames_cnt_d = '0;
                    stop_pend_d  = 1'b0;
                    err_clr      = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cyc_q == CYC_LAST) begin
                    frame_end    = 1'b1;
                    frame_done_d = 1'b1;
                    frames_cnt_d = nf;
                    // A stop on the last cycle still counts as pending.
                    if (stop_pend_q || stop ||
                        ((num_frames_q != '0) && (nf == num_frames_q))) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            gap_q        <= '0;
            frames_cnt_q <= '0;
            num_frames_q <= '0;
            stop_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            gap_q        <= gap_d;
            frames_cnt_q <= frames_cnt_d;
            num_frames_q <= num_frames_d;
            stop_pend_q  <= stop_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign run         = (state_q == S_RUN);
    assign gen_en      = run;
    assign busy        = (state_q != S_IDLE);
    assign frame_start = run && (cyc_q == '0);
    assign frame_done  = frame_done_q;
    assign frames_cnt  = frames_cnt_q;

    lcd_pix_addr_gen #(
        .ADDR_W  (ADDR_W),
        .PCNT_W  (PCNT_W),
        .PIX_EXP (PIX_EXP)
    ) u_pix (
        .clk        (clk),
        .rst        (rst),
        .clr        (frame_start),
        .en         (run),
        .pix_active (pix_active),
        .frame_end  (frame_end),
        .err_clr    (err_clr),
        .pix_valid  (pix_valid),
        .pix_addr   (pix_addr),
        .px_err     (px_err)
    );

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: directed scenarios with random pixel placement,
// checked against an arithmetic frame-timeline model.
module tb_lcd_frame_sequencer;

    localparam int CNT_W  = 8;
    localparam int ADDR_W = 8;
    localparam int FC     = 8 * 16;
    localparam int GAP    = 4;
    localparam int P      = FC + GAP;
    localparam int PIXN   = 5 * 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  num_frames;
    logic              pix_active;
    logic              gen_en;
    logic              busy;
    logic              frame_start;
    logic              frame_done;
    logic [CNT_W-1:0]  frames_cnt;
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic              px_err;

    int n_chk;
    int n_fail;
    bit err_m;

    lcd_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .num_frames  (num_frames),
        .pix_active  (pix_active),
        .gen_en      (gen_en),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frames_cnt  (frames_cnt),
        .pix_valid   (pix_valid),
        .pix_addr    (pix_addr),
        .px_err      (px_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int r,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s rel=%0d observed=%0h expected=%0h", tag, r, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":gen_en"}, -1, 32'(gen_en), 0);
        chk({tag, ":busy"}, -1, 32'(busy), 0);
        chk({tag, ":frame_start"}, -1, 32'(frame_start), 0);
        chk({tag, ":frame_done"}, -1, 32'(frame_done), 0);
        chk({tag, ":frames_cnt"}, -1, 32'(frames_cnt), 0);
        chk({tag, ":pix_valid"}, -1, 32'(pix_valid), 0);
        chk({tag, ":pix_addr"}, -1, 32'(pix_addr), 0);
        chk({tag, ":px_err"}, -1, 32'(px_err), 0);
    endtask

    // One run from a start pulse. Called at a negedge.
    // nfrm: frames that complete; bend: first rel cycle with busy low.
    task automatic run_seq(input string nm, input int nf_prog, input int nfrm,
                           input int bend, input int stop_at, input int pix0,
                           input int mid_start, input bit st_stop, input int rst_at);
        int  cnt;
        int  addr_e;
        bit  pv_e;
        bit  act;
        int  k;
        int  ph;
        bit  run;
        bit  fd;
        int  fc;
        int  tgt;
        int  need;
        start      = 1'b1;
        stop       = st_stop;
        num_frames = CNT_W'(nf_prog);
        pix_active = 1'($urandom);
        @(negedge clk);
        start      = 1'b0;
        stop       = 1'b0;
        num_frames = CNT_W'($urandom);
        err_m      = 1'b0;
        cnt        = 0;
        addr_e     = 0;
        pv_e       = 1'b0;
        for (int r = 0; r <= bend + 3; r++) begin
            k   = r / P;
            ph  = r % P;
            run = (r < bend) && (ph < FC);
            fd  = (ph == FC) && (k < nfrm) && (r <= bend);
            if (r < FC) fc = 0;
            else begin
                fc = (r - FC) / P + 1;
                if (fc > nfrm) fc = nfrm;
            end
            if (fd && (cnt != PIXN)) err_m = 1'b1;
            if (run && (ph == 0)) cnt = 0;
            chk({nm, ":gen_en"}, r, 32'(gen_en), 32'(run));
            chk({nm, ":busy"}, r, 32'(busy), 32'(r < bend));
            chk({nm, ":frame_start"}, r, 32'(frame_start), 32'(run && ph == 0));
            chk({nm, ":frame_done"}, r, 32'(frame_done), 32'(fd));
            chk({nm, ":frames_cnt"}, r, 32'(frames_cnt), 32'(fc));
            chk({nm, ":pix_valid"}, r, 32'(pix_valid), 32'(pv_e));
            if (pv_e) chk({nm, ":pix_addr"}, r, 32'(pix_addr), 32'(addr_e));
            chk({nm, ":px_err"}, r, 32'(px_err), 32'(err_m));
            if (r == rst_at) begin
                #1 rst = 1'b1;
                #1 chk_reset({nm, ":async_rst"});
                err_m = 1'b0;
                @(negedge clk);
                chk_reset({nm, ":held_rst"});
                rst = 1'b0;
                pix_active = 1'b0;
                return;
            end
            tgt = (k == 0) ? pix0 : PIXN;
            if (run) begin
                need = tgt - cnt;
                act  = (need > 0) &&
                       (int'($urandom_range(FC - 1 - ph)) < need);
            end else begin
                act = 1'($urandom);
            end
            pix_active = act;
            pv_e = run && act;
            if (pv_e) begin
                addr_e = cnt;
                cnt++;
            end
            stop  = (r == stop_at);
            start = (r == mid_start);
            @(negedge clk);
        end
        start      = 1'b0;
        stop       = 1'b0;
        pix_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nr;
        n_chk      = 0;
        n_fail     = 0;
        err_m      = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        num_frames = '0;
        pix_active = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("idle");

        run_seq("two", 2, 2, P + FC, -1, PIXN, -1, 1'b0, -1);
        run_seq("cont_stop", 0, 3, 2 * P + FC, 2 * P + 60, PIXN, -1, 1'b0, -1);
        run_seq("gap_stop", 0, 1, FC + 2, FC + 1, PIXN, -1, 1'b0, -1);
        run_seq("short_px", 2, 2, P + FC, -1, PIXN - 1, -1, 1'b0, -1);
        chk("short_px:err_idle", -1, 32'(px_err), 1);
        run_seq("busy_start", 2, 2, P + FC, -1, PIXN, 40, 1'b1, -1);
        nr = int'($urandom_range(3, 1));
        run_seq("rand_n", nr, nr, (nr - 1) * P + FC, -1, PIXN, -1, 1'b0, -1);
        run_seq("rst_mid", 2, 2, P + FC, -1, PIXN, -1, 1'b0, 70);
        run_seq("after_rst", 2, 2, P + FC, -1, PIXN, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
